vga_timing_detect: RTL and testbench

Receive-side counterpart of the VGA timing generator. It watches an incoming h_sync/v_sync/h_active/v_active stream and measures the horizontal timing in clocks and the vertical timing in lines, including sync polarity. It reports a locked, stable mode so downstream capture or scaler logic can be configured from the measured values. It sits at the video input, in the same clock domain as the incoming pixel stream.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_timing_axis_meter.sv | 88 ++++++++
 rtl/vga_timing_detect.sv | 138 +++++++++++++
 tb/tb_vga_timing_detect.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing detector: field width,
// saturation value, lock FSM states and the measured-mode snapshot.
package vga_timing_pkg;

  localparam int FIELD_W = 10;
  localparam logic [FIELD_W-1:0] SAT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH,
    CAPTURE,
    VERIFY,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] h_total;
    logic [FIELD_W-1:0] h_sync_len;
    logic [FIELD_W-1:0] h_back;
    logic [FIELD_W-1:0] h_active_len;
    logic [FIELD_W-1:0] v_total;
    logic [FIELD_W-1:0] v_sync_len;
    logic [FIELD_W-1:0] v_back;
    logic [FIELD_W-1:0] v_active_len;
    logic               h_pol;
    logic               v_pol;
  } snap_t;

endpackage

// File: rtl/vga_timing_axis_meter.sv
// One timing axis: measures period, active width, sync width/polarity and
// sync-start-to-active distance in units of count_en, publishing on active rise.
module vga_timing_axis_meter
  import vga_timing_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               sync,
  input  logic               sync_prev,
  input  logic               active,
  input  logic               active_prev,
  input  logic               count_en,
  output logic [FIELD_W-1:0] total,
  output logic [FIELD_W-1:0] sync_len,
  output logic [FIELD_W-1:0] back,
  output logic [FIELD_W-1:0] active_len,
  output logic               pol,
  output logic               done,
  output logic               sat
);

  logic [FIELD_W-1:0] per_cnt, act_cnt, hi_cnt, lo_cnt, back_r_cnt, back_f_cnt;
  logic [FIELD_W-1:0] act_w, hi_w, lo_w, en_ext;
  logic sync_rise, sync_fall, act_rise, act_fall, pol_new;

  function automatic logic [FIELD_W-1:0] sat_add(input logic [FIELD_W-1:0] a,
                                                 input logic [FIELD_W-1:0] inc);
    if (a == SAT_MAX) return SAT_MAX;
    return a + inc;
  endfunction

  assign en_ext    = {{(FIELD_W-1){1'b0}}, count_en};
  assign sync_rise = sync & ~sync_prev;
  assign sync_fall = ~sync & sync_prev;
  assign act_rise  = active & ~active_prev;
  assign act_fall  = ~active & active_prev;
  // Polarity is taken from the widths just measured so the back distance
  // is referenced to the correct edge even on the first valid period.
  assign pol_new   = hi_w < lo_w;
  assign sat       = (total == SAT_MAX) | (sync_len == SAT_MAX) |
                     (back == SAT_MAX) | (active_len == SAT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt    <= '0;
      act_cnt    <= '0;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      back_r_cnt <= '0;
      back_f_cnt <= '0;
      act_w      <= '0;
      hi_w       <= '0;
      lo_w       <= '0;
      total      <= '0;
      sync_len   <= '0;
      back       <= '0;
      active_len <= '0;
      pol        <= 1'b0;
      done       <= 1'b0;
    end else begin
      per_cnt    <= act_rise ? '0 : sat_add(per_cnt, en_ext);
      back_r_cnt <= sync_rise ? en_ext : sat_add(back_r_cnt, en_ext);
      back_f_cnt <= sync_fall ? en_ext : sat_add(back_f_cnt, en_ext);

      if (act_rise)    act_cnt <= en_ext;
      else if (active) act_cnt <= sat_add(act_cnt, en_ext);
      if (act_fall)    act_w   <= act_cnt;

      if (sync_rise)   hi_cnt  <= en_ext;
      else if (sync)   hi_cnt  <= sat_add(hi_cnt, en_ext);
      if (sync_fall)   hi_w    <= hi_cnt;

      if (sync_fall)   lo_cnt  <= en_ext;
      else if (!sync)  lo_cnt  <= sat_add(lo_cnt, en_ext);
      if (sync_rise)   lo_w    <= lo_cnt;

      done <= act_rise;
      if (act_rise) begin
        total      <= sat_add(per_cnt, en_ext);
        active_len <= act_w;
        sync_len   <= pol_new ? hi_w : lo_w;
        back       <= pol_new ? back_r_cnt : back_f_cnt;
        pol        <= pol_new;
      end
    end
  end

endmodule

// File: rtl/vga_timing_detect.sv
// Measures an incoming VGA timing stream and reports a locked mode once the
// per-frame snapshot repeats on consecutive frame boundaries.
module vga_timing_detect
  import vga_timing_pkg::*;
#(
  parameter int TIMEOUT_CLKS  = 1023,
  parameter int TIMEOUT_LINES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               h_active_in,
  input  logic               v_active_in,
  output logic [FIELD_W-1:0] h_total,
  output logic [FIELD_W-1:0] h_sync_len,
  output logic [FIELD_W-1:0] h_back,
  output logic [FIELD_W-1:0] h_active_len,
  output logic [FIELD_W-1:0] v_total,
  output logic [FIELD_W-1:0] v_sync_len,
  output logic [FIELD_W-1:0] v_back,
  output logic [FIELD_W-1:0] v_active_len,
  output logic               h_pol,
  output logic               v_pol,
  output logic               locked,
  output logic               update
);

  logic s_h_sync, s_v_sync, s_h_active, s_v_active;
  logic p_h_sync, p_v_sync, p_h_active, p_v_active;
  logic tick, h_done, v_done, h_sat, v_sat, snap_valid, timeout;
  logic store, load;
  logic [FIELD_W-1:0] clk_cnt, line_cnt;
  snap_t  snap, stored, out_q;
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      {s_h_sync, s_v_sync, s_h_active, s_v_active} <= '0;
      {p_h_sync, p_v_sync, p_h_active, p_v_active} <= '0;
    end else begin
      {s_h_sync, s_v_sync, s_h_active, s_v_active} <= {h_sync_in, v_sync_in, h_active_in, v_active_in};
      {p_h_sync, p_v_sync, p_h_active, p_v_active} <= {s_h_sync, s_v_sync, s_h_active, s_v_active};
    end
  end

  assign tick = s_h_active & ~p_h_active;

  vga_timing_axis_meter u_h_meter (
    .clk(clk), .reset(reset), .sync(s_h_sync), .sync_prev(p_h_sync),
    .active(s_h_active), .active_prev(p_h_active), .count_en(1'b1),
    .total(snap.h_total), .sync_len(snap.h_sync_len), .back(snap.h_back),
    .active_len(snap.h_active_len), .pol(snap.h_pol), .done(h_done), .sat(h_sat)
  );

  vga_timing_axis_meter u_v_meter (
    .clk(clk), .reset(reset), .sync(s_v_sync), .sync_prev(p_v_sync),
    .active(s_v_active), .active_prev(p_v_active), .count_en(tick),
    .total(snap.v_total), .sync_len(snap.v_sync_len), .back(snap.v_back),
    .active_len(snap.v_active_len), .pol(snap.v_pol), .done(v_done), .sat(v_sat)
  );

  assign snap_valid = ~h_sat & ~v_sat;

  // Loss-of-signal watchdogs, cleared by each published line / frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (h_done) clk_cnt <= '0;
      else if (clk_cnt != FIELD_W'(TIMEOUT_CLKS)) clk_cnt <= clk_cnt + 1'b1;
      if (v_done) line_cnt <= '0;
      else if (h_done && line_cnt != FIELD_W'(TIMEOUT_LINES)) line_cnt <= line_cnt + 1'b1;
    end
  end

  assign timeout = (clk_cnt == FIELD_W'(TIMEOUT_CLKS)) | (line_cnt == FIELD_W'(TIMEOUT_LINES));

  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      SEARCH:  if (v_done) state_d = CAPTURE;
      CAPTURE: if (v_done) begin
        state_d = VERIFY;
        store   = 1'b1;
      end
      VERIFY:  if (v_done) begin
        if (snap_valid && snap == stored) begin
          state_d = LOCKED;
          load    = 1'b1;
        end else begin
          store   = 1'b1;
        end
      end
      LOCKED:  if (v_done && !(snap_valid && snap == stored)) begin
        state_d = VERIFY;
        store   = 1'b1;
      end
    endcase
    if (!enable || timeout) begin
      state_d = SEARCH;
      store   = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      stored  <= '0;
      out_q   <= '0;
      locked  <= 1'b0;
      update  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (store) stored <= snap;
      if (load)  out_q  <= snap;
      locked  <= (state_d == LOCKED);
      update  <= load;
    end
  end

  assign h_total      = out_q.h_total;
  assign h_sync_len   = out_q.h_sync_len;
  assign h_back       = out_q.h_back;
  assign h_active_len = out_q.h_active_len;
  assign v_total      = out_q.v_total;
  assign v_sync_len   = out_q.v_sync_len;
  assign v_back       = out_q.v_back;
  assign v_active_len = out_q.v_active_len;
  assign h_pol        = out_q.h_pol;
  assign v_pol        = out_q.v_pol;

endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed-stream bench for vga_timing_detect with an update-driven scoreboard.
module tb_vga_timing_detect;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic reset, enable, hs, vs, ha, va;
  logic [9:0] h_total, h_sync_len, h_back, h_active_len;
  logic [9:0] v_total, v_sync_len, v_back, v_active_len;
  logic h_pol, v_pol, locked, update;

  int n_checks = 0;
  int n_fail   = 0;
  snap_t exp_q[$];

  typedef struct {
    int htot, hsync, hback, hact;
    int vtot, vsync, vback, vact;
    bit hpol, vpol;
  } mode_t;

  always #5 clk = ~clk;

  vga_timing_detect dut (
    .clk(clk), .reset(reset), .enable(enable),
    .h_sync_in(hs), .v_sync_in(vs), .h_active_in(ha), .v_active_in(va),
    .h_total(h_total), .h_sync_len(h_sync_len), .h_back(h_back), .h_active_len(h_active_len),
    .v_total(v_total), .v_sync_len(v_sync_len), .v_back(v_back), .v_active_len(v_active_len),
    .h_pol(h_pol), .v_pol(v_pol), .locked(locked), .update(update)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic snap_t exp_of(input mode_t m);
    snap_t s;
    s.h_total      = 10'(m.htot);
    s.h_sync_len   = 10'(m.hsync);
    s.h_back       = 10'(m.hback);
    s.h_active_len = 10'(m.hact);
    s.v_total      = 10'(m.vtot);
    s.v_sync_len   = 10'(m.vsync);
    s.v_back       = 10'(m.vback);
    s.v_active_len = 10'(m.vact);
    s.h_pol        = m.hpol;
    s.v_pol        = m.vpol;
    return s;
  endfunction

  task automatic cmp_outputs(input string tag, input snap_t e);
    check({tag, "_h_total"},      h_total,      e.h_total);
    check({tag, "_h_sync_len"},   h_sync_len,   e.h_sync_len);
    check({tag, "_h_back"},       h_back,       e.h_back);
    check({tag, "_h_active_len"}, h_active_len, e.h_active_len);
    check({tag, "_v_total"},      v_total,      e.v_total);
    check({tag, "_v_sync_len"},   v_sync_len,   e.v_sync_len);
    check({tag, "_v_back"},       v_back,       e.v_back);
    check({tag, "_v_active_len"}, v_active_len, e.v_active_len);
    check({tag, "_h_pol"},        h_pol,        e.h_pol);
    check({tag, "_v_pol"},        v_pol,        e.v_pol);
  endtask

  // Scoreboard monitor: every update pulse consumes one expected mode.
  always @(negedge clk) begin
    if (update === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got update with h_total=%0d, expected no update", h_total);
      end else begin
        cmp_outputs("upd", exp_q.pop_front());
      end
    end
  end

  task automatic idle(input mode_t m, input int n);
    repeat (n) begin
      @(negedge clk);
      hs = ~m.hpol;
      vs = ~m.vpol;
      ha = 1'b0;
      va = 1'b0;
    end
  endtask

  task automatic do_reset(input mode_t m);
    idle(m, 1);
    reset = 1'b1;
    idle(m, 3);
    reset = 1'b0;
    idle(m, 2);
  endtask

  // One frame; lines at or after sw_line use m1, reset pulses on rst_line.
  task automatic send_frame(input mode_t m0, input mode_t m1, input int sw_line, input int rst_line);
    mode_t m;
    for (int l = 0; l < m0.vtot; l++) begin
      m = (l >= sw_line) ? m1 : m0;
      for (int c = 0; c < m.htot; c++) begin
        @(negedge clk);
        hs = (c < m.hsync) ? m.hpol : ~m.hpol;
        ha = (c >= m.hback) && (c < m.hback + m.hact);
        vs = (l < m.vsync) ? m.vpol : ~m.vpol;
        va = (l >= m.vback) && (l < m.vback + m.vact);
        if (l == rst_line && c == 20) reset = 1'b1;
        if (l == rst_line && c == 21) begin
          reset = 1'b0;
          check("rstmid_locked",  locked,  0);
          check("rstmid_update",  update,  0);
          check("rstmid_h_total", h_total, 0);
          check("rstmid_v_total", v_total, 0);
          check("rstmid_h_back",  h_back,  0);
        end
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mode_t m_a, m_p, m_s, m_s42, m_l;
    snap_t zero;
    m_a   = '{800, 96, 144, 640, 8, 2, 3, 4, 1'b0, 1'b0};
    m_p   = '{40, 6, 10, 24, 10, 2, 3, 5, 1'b1, 1'b1};
    m_s   = '{40, 6, 10, 24, 10, 2, 3, 5, 1'b0, 1'b0};
    m_s42 = '{42, 6, 10, 24, 10, 2, 3, 5, 1'b0, 1'b0};
    m_l   = '{1100, 6, 10, 24, 6, 1, 2, 2, 1'b0, 1'b0};
    zero  = '0;
    enable = 1'b1;
    reset  = 1'b1;
    hs = 1'b1; vs = 1'b1; ha = 1'b0; va = 1'b0;

    // Reset state
    do_reset(m_a);
    cmp_outputs("reset", zero);
    check("reset_locked", locked, 0);
    check("reset_update", update, 0);
    check("reset_state", 32'(dut.state_q), 32'(SEARCH));

    // 800-clock lines, negative syncs: lock on the third boundary
    send_frame(m_a, m_a, 1000, -1);
    send_frame(m_a, m_a, 1000, -1);
    check("a_locked_after_2", locked, 0);
    exp_q.push_back(exp_of(m_a));
    send_frame(m_a, m_a, 1000, -1);
    check("a_locked_after_3", locked, 1);
    send_frame(m_a, m_a, 1000, -1);
    check("a_locked_after_4", locked, 1);
    cmp_outputs("a_hold", exp_of(m_a));

    // Positive syncs
    do_reset(m_p);
    send_frame(m_p, m_p, 1000, -1);
    send_frame(m_p, m_p, 1000, -1);
    check("p_locked_after_2", locked, 0);
    exp_q.push_back(exp_of(m_p));
    send_frame(m_p, m_p, 1000, -1);
    check("p_locked_after_3", locked, 1);

    // Line length change mid-frame, then relock
    do_reset(m_s);
    send_frame(m_s, m_s, 1000, -1);
    send_frame(m_s, m_s, 1000, -1);
    exp_q.push_back(exp_of(m_s));
    send_frame(m_s, m_s, 1000, -1);
    check("s_locked", locked, 1);
    send_frame(m_s, m_s42, 5, -1);
    check("chg_still_locked", locked, 1);
    send_frame(m_s42, m_s42, 1000, -1);
    check("chg_unlocked", locked, 0);
    check("chg_hold_h_total", h_total, 40);
    exp_q.push_back(exp_of(m_s42));
    send_frame(m_s42, m_s42, 1000, -1);
    check("chg_relocked", locked, 1);

    // Loss of line ticks
    idle(m_s42, 1100);
    check("timeout_locked", locked, 0);
    check("timeout_state", 32'(dut.state_q), 32'(SEARCH));
    cmp_outputs("timeout_hold", exp_of(m_s42));

    // Over-range line length never locks
    do_reset(m_l);
    for (int f = 0; f < 4; f++) begin
      send_frame(m_l, m_l, 1000, -1);
      check("long_line_locked", locked, 0);
    end

    // Reset mid-frame while locked
    do_reset(m_s);
    send_frame(m_s, m_s, 1000, -1);
    send_frame(m_s, m_s, 1000, -1);
    exp_q.push_back(exp_of(m_s));
    send_frame(m_s, m_s, 1000, -1);
    check("r_locked", locked, 1);
    send_frame(m_s, m_s, 1000, 6);
    send_frame(m_s, m_s, 1000, -1);
    send_frame(m_s, m_s, 1000, -1);
    check("r_locked_after_2", locked, 0);
    exp_q.push_back(exp_of(m_s));
    send_frame(m_s, m_s, 1000, -1);
    check("r_locked_after_3", locked, 1);

    // Enable low drops lock but keeps outputs
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("enable_locked", locked, 0);
    check("enable_hold_h_total", h_total, 40);
    enable = 1'b1;
    idle(m_s, 2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
